// File: rtl/code_serializer.sv
// Serializes a WIDTH-bit code word onto ser_out, holding each bit BIT_CYCLES clocks,
// then forces GAP_CYCLES idle-high clocks before accepting the next word.
module code_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             done
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             in_ready_q, in_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_active_q, ser_active_d;
  logic             done_q, done_d;

  // Next state, counters and the registered-output values for the coming cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    sreg_d       = sreg_q;
    done_d       = 1'b0;
    in_ready_d   = 1'b0;
    ser_active_d = 1'b0;
    ser_out_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = SHIFT;
          sreg_d  = in_data;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_d  = idx_q + 1'b1;
            sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered
    in_ready_d   = (state_d == IDLE);
    ser_active_d = (state_d == SHIFT);
    if (state_d == SHIFT) begin
      ser_out_d = (MSB_FIRST != 0) ? sreg_d[WIDTH-1] : sreg_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      sreg_q       <= '0;
      in_ready_q   <= 1'b0;
      ser_out_q    <= 1'b1;
      ser_active_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      sreg_q       <= sreg_d;
      in_ready_q   <= in_ready_d;
      ser_out_q    <= ser_out_d;
      ser_active_q <= ser_active_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_active = ser_active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// Three serializer configurations checked every cycle against a timeline model,
// plus directed waveform, reset-abort, back-to-back and "001" detector scenarios.
module tb_code_serializer;

  logic            clk = 1'b0;
  logic [2:0]      rst = 3'b111;
  logic [2:0]      valid = '0;
  logic [2:0][7:0] data = '0;
  logic [2:0]      ready, sout, act, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u0: defaults; u1: 3 clocks per bit, LSB first; u2: no gap
  code_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(2), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .reset(rst[0]), .in_valid(valid[0]), .in_data(data[0]),
    .in_ready(ready[0]), .ser_out(sout[0]), .ser_active(act[0]), .done(done[0]));
  code_serializer #(.WIDTH(8), .BIT_CYCLES(3), .GAP_CYCLES(2), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .in_valid(valid[1]), .in_data(data[1]),
    .in_ready(ready[1]), .ser_out(sout[1]), .ser_active(act[1]), .done(done[1]));
  code_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(0), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .in_valid(valid[2]), .in_data(data[2]),
    .in_ready(ready[2]), .ser_out(sout[2]), .ser_active(act[2]), .done(done[2]));

  function automatic int bcyc(input int i);
    return (i == 1) ? 3 : 1;
  endfunction
  function automatic int gcyc(input int i);
    return (i == 2) ? 0 : 2;
  endfunction
  function automatic bit msb1st(input int i);
    return (i != 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: m_t = clocks since transfer (0 = idle); bits occupy t=1..8*B, gap follows
  int         m_t[3]   = '{default: 0};
  logic [7:0] m_word[3] = '{default: 8'h00};
  logic [2:0] m_rdy = '0;
  logic [2:0] m_dn  = '0;
  logic [2:0] m_acc = '0;
  int         m_len, m_tot;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_len = 8 * bcyc(i);
      m_tot = m_len + gcyc(i);
      m_acc[i] = 1'b0;
      if (rst[i]) begin
        m_t[i] = 0; m_rdy[i] = 1'b0; m_dn[i] = 1'b0;
      end else begin
        m_dn[i] = (m_t[i] == m_len);
        if (m_rdy[i] && valid[i]) begin
          m_word[i] = data[i]; m_t[i] = 1; m_acc[i] = 1'b1;
        end else if (m_t[i] > 0) begin
          m_t[i]++;
          if (m_t[i] > m_tot) m_t[i] = 0;
        end
        m_rdy[i] = (m_t[i] == 0);
      end
    end
  end

  function automatic logic exp_active(input int i);
    return (m_t[i] >= 1) && (m_t[i] <= 8 * bcyc(i));
  endfunction

  function automatic logic exp_out(input int i);
    int k;
    if (!exp_active(i)) return 1'b1;
    k = (m_t[i] - 1) / bcyc(i);
    return msb1st(i) ? m_word[i][7-k] : m_word[i][k];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.ser_out", i),    32'(sout[i]),  32'(exp_out(i)));
      check($sformatf("u%0d.ser_active", i), 32'(act[i]),   32'(exp_active(i)));
      check($sformatf("u%0d.done", i),       32'(done[i]),  32'(m_dn[i]));
      check($sformatf("u%0d.in_ready", i),   32'(ready[i]), 32'(m_rdy[i]));
    end
  end

  // Send one word on u0 and check the 11-clock waveform plus a "001" detector count
  task automatic run_word0(input logic [7:0] w, input int exp_unlock);
    logic [2:0] hist;
    int unl;
    hist = 3'b111;
    unl  = 0;
    check("u0.ready_before_send", 32'(ready[0]), 32'd1);
    valid[0] = 1'b1;
    data[0]  = w;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid[0] = 1'b0;
        data[0]  = ~w;
      end
      check($sformatf("dir.out c%0d", c), 32'(sout[0]), (c <= 8) ? 32'(w[8-c]) : 32'd1);
      check($sformatf("dir.act c%0d", c), 32'(act[0]), 32'(c <= 8));
      check($sformatf("dir.done c%0d", c), 32'(done[0]), 32'(c == 9));
      check($sformatf("dir.rdy c%0d", c), 32'(ready[0]), 32'(c == 11));
      hist = {hist[1:0], sout[0]};
      if (hist == 3'b001) unl++;
    end
    check("det.unlock_count", 32'(unl), 32'(exp_unlock));
  endtask

  initial begin
    int idle_clks;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.u%0d.ready", i), 32'(ready[i]), 32'd0);
      check($sformatf("rst.u%0d.out", i),   32'(sout[i]),  32'd1);
      check($sformatf("rst.u%0d.act", i),   32'(act[i]),   32'd0);
      check($sformatf("rst.u%0d.done", i),  32'(done[i]),  32'd0);
    end
    rst = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("rel.u%0d.ready", i), 32'(ready[i]), 32'd1);

    run_word0(8'hF9, 1);
    run_word0(8'hFF, 0);

    // Reset in clock 4 of a word aborts it without a done pulse
    valid[0] = 1'b1;
    data[0]  = 8'hF9;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort.out", 32'(sout[0]), 32'd1);
    check("abort.act", 32'(act[0]), 32'd0);
    check("abort.done", 32'(done[0]), 32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort.ready_after_release", 32'(ready[0]), 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort.no_done", 32'(done[0]), 32'd0);
    end

    // Three clocks per bit, LSB first: 8'h06
    valid[1] = 1'b1;
    data[1]  = 8'h06;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) valid[1] = 1'b0;
      check($sformatf("slow.out c%0d", c), 32'(sout[1]), (c >= 4 && c <= 9) ? 32'd1 : 32'd0 | 32'(c == 25));
      check($sformatf("slow.act c%0d", c), 32'(act[1]), 32'(c <= 24));
      check($sformatf("slow.done c%0d", c), 32'(done[1]), 32'(c == 25));
    end

    // No gap, valid held: 8'h01 twice with a single idle-high clock between
    valid[2] = 1'b1;
    data[2]  = 8'h01;
    idle_clks = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 10) valid[2] = 1'b0;
      if (c <= 17 && !act[2]) idle_clks++;
      if (c == 8 || c == 17) check($sformatf("b2b.last_bit c%0d", c), 32'(sout[2]), 32'd1);
      if (c == 9) begin
        check("b2b.idle_out", 32'(sout[2]), 32'd1);
        check("b2b.idle_ready", 32'(ready[2]), 32'd1);
      end
      if (c == 10) check("b2b.first_bit2", 32'(sout[2]), 32'd0);
      check($sformatf("b2b.done c%0d", c), 32'(done[2]), 32'(c == 9 || c == 18));
    end
    check("b2b.idle_clocks", 32'(idle_clks), 32'd1);

    // Random traffic: data changes right after each transfer, i.e. mid-word
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (m_acc[i]) begin
          valid[i] = ($urandom_range(3) != 0);
          data[i]  = 8'($urandom);
        end else if (!valid[i] && $urandom_range(7) == 0) begin
          valid[i] = 1'b1;
          data[i]  = 8'($urandom);
        end
        rst[i] = ($urandom_range(299) == 0);
      end
    end
    valid = '0;
    rst   = '0;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
